// File: rtl/shift_pkg.sv
// Shared shifter types for the execute-stage shift datapath.
package shift_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [4:0]      shift;
        shift_op_e       op;
    } shift_req_t;

    // One-entry result register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } oreg_state_e;

endpackage

// File: rtl/barrel_shift.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA, ROR.
module barrel_shift
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [4:0]      shift,
    input  shift_op_e       op,
    output logic [XLEN-1:0] q
);

    logic [2*XLEN-1:0] dbl;

    // Select the shift flavour; rotate takes the low half of {a,a} >> shift
    always_comb begin
        dbl = {a, a} >> shift;
        q   = a;
        case (op)
            SH_SLL:  q = a << shift;
            SH_SRL:  q = a >> shift;
            SH_SRA:  q = $unsigned($signed(a) >>> shift);
            SH_ROR:  q = dbl[XLEN-1:0];
            default: q = a;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts at rr_ptr and wraps modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    input  logic                    enable,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic        found;
    int unsigned idx;

    // First valid requester at or after rr_ptr wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        if (enable) begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                idx = (32'(rr_ptr) + off) % NREQ;
                if (!found && req_valid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_id    = IDW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel_shift between NREQ requesters with round-robin grant and
// a one-entry valid/ready result register.
// SHIFT_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins), no rr_ptr.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*5-1:0]    req_shift,
    input  logic [NREQ*2-1:0]    req_op,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_q,
    output logic [IDW-1:0]       resp_id,
    input  logic                 resp_ready
);

    shift_req_t  reqs [NREQ];
    shift_req_t  sel;
    oreg_state_e state, state_nxt;
    logic        can_accept;
    logic        enable;
    logic        grant_any;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  rr_ptr;
    logic [XLEN-1:0] sh_q;

    // Unpack flat port vectors into per-requester structs
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            reqs[i].a     = req_a[i*XLEN +: XLEN];
            reqs[i].shift = req_shift[i*5 +: 5];
            reqs[i].op    = shift_op_e'(req_op[i*2 +: 2]);
        end
    end

    // Output-register next state; grants are masked while reset is high
    always_comb begin
        state_nxt  = state;
        resp_valid = (state == ST_FULL);
        can_accept = (state == ST_EMPTY) || resp_ready;
        enable     = can_accept && !reset;
        case (state)
            ST_EMPTY: if (grant_any) state_nxt = ST_FULL;
            ST_FULL:  if (resp_ready && !grant_any) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (enable),
        .grant     (req_ready),
        .grant_id  (grant_id)
    );

    assign grant_any = |req_ready;
    // grant_id is 0 with no grant, so the idle mux selects requester 0
    assign sel       = reqs[grant_id];

    barrel_shift u_shift (
        .a     (sel.a),
        .shift (sel.shift),
        .op    (sel.op),
        .q     (sh_q)
    );

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDW-1:0] ptr_nxt;

    // Pointer moves just past the granted index
    always_comb begin
        ptr_nxt = grant_id + 1'b1;
        if (32'(grant_id) == NREQ - 1) ptr_nxt = '0;
    end

    // Round-robin pointer register, held when nothing is granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          rr_ptr <= '0;
        else if (grant_any) rr_ptr <= ptr_nxt;
    end
`endif

    // State and result register; a grant loads the shifter result and its index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            resp_q  <= '0;
            resp_id <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                resp_q  <= sh_q;
                resp_id <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed table-driven bench for shift_arbiter (NREQ=2).
module tb_shift_arbiter;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_a = '0;
    logic [9:0]  req_shift = '0;
    logic [3:0]  req_op = '0;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic [31:0] resp_q;
    logic [0:0]  resp_id;
    logic        resp_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, a1;
        logic [4:0]  s0, s1;
        logic [1:0]  o0, o1;
        logic        rdy;
        logic [1:0]  g;
        logic        rv;
        logic [31:0] q;
        logic        id;
    } vec_t;

    vec_t vecs [12];

    shift_arbiter #(.NREQ(2), .IDW(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_shift  (req_shift),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_q     (resp_q),
        .resp_id    (resp_id),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid,
                                input logic [31:0] a0, input logic [4:0] s0, input logic [1:0] o0,
                                input logic [31:0] a1, input logic [4:0] s1, input logic [1:0] o1,
                                input logic rdy, input logic [1:0] g, input logic rv,
                                input logic [31:0] q, input logic id);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.s0 = s0; v.o0 = o0;
        v.a1 = a1; v.s1 = s1; v.o1 = o1;
        v.rdy = rdy; v.g = g; v.rv = rv; v.q = q; v.id = id;
        return v;
    endfunction

    // Entered just after a rising edge; leaves just after the next one
    task automatic step(input string tag, input vec_t v);
        req_valid  = v.valid;
        req_a      = {v.a1, v.a0};
        req_shift  = {v.s1, v.s0};
        req_op     = {v.o1, v.o0};
        resp_ready = v.rdy;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(v.g));
        @(posedge clk);
        #1;
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(v.rv));
        chk({tag, ".resp_q"}, resp_q, v.q);
        chk({tag, ".resp_id"}, 32'(resp_id), 32'(v.id));
    endtask

    initial begin
        vec_t h;
        // single request, then op sweep on requester 1 (only one valid => always granted)
        vecs[0]  = mk(2'b01, 32'hF000DEAD, 5'd4, 2'b01, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'h0F000DEA, 1'b0);
        vecs[1]  = mk(2'b10, 32'h0, 5'd0, 2'b00, 32'hF000DEAD, 5'd4, 2'b00, 1'b1, 2'b10, 1'b1, 32'h000DEAD0, 1'b1);
        vecs[2]  = mk(2'b10, 32'h0, 5'd0, 2'b00, 32'hF000DEAD, 5'd4, 2'b10, 1'b1, 2'b10, 1'b1, 32'hFF000DEA, 1'b1);
        vecs[3]  = mk(2'b10, 32'h0, 5'd0, 2'b00, 32'hF000DEAD, 5'd4, 2'b11, 1'b1, 2'b10, 1'b1, 32'hDF000DEA, 1'b1);
        vecs[4]  = mk(2'b10, 32'h0, 5'd0, 2'b00, 32'hF000DEAD, 5'd0, 2'b01, 1'b1, 2'b10, 1'b1, 32'hF000DEAD, 1'b1);
        // drain with no request: FULL -> EMPTY, data held
        vecs[5]  = mk(2'b00, 32'h0, 5'd0, 2'b00, 32'h0, 5'd0, 2'b00, 1'b1, 2'b00, 1'b0, 32'hF000DEAD, 1'b1);
        // both valid: alternate 0,1,0,1 (fixed priority: always 0); shift-31 boundaries
        vecs[6]  = mk(2'b11, 32'h1, 5'd31, 2'b00, 32'h80000000, 5'd31, 2'b10, 1'b1, 2'b01, 1'b1, 32'h80000000, 1'b0);
        vecs[7]  = mk(2'b11, 32'h1, 5'd31, 2'b00, 32'h80000000, 5'd31, 2'b10, 1'b1,
                      FIXED ? 2'b01 : 2'b10, 1'b1, FIXED ? 32'h80000000 : 32'hFFFFFFFF, !FIXED);
        vecs[8]  = mk(2'b11, 32'h1, 5'd31, 2'b00, 32'h80000000, 5'd31, 2'b10, 1'b1, 2'b01, 1'b1, 32'h80000000, 1'b0);
        vecs[9]  = mk(2'b11, 32'h1, 5'd31, 2'b00, 32'h80000000, 5'd31, 2'b10, 1'b1,
                      FIXED ? 2'b01 : 2'b10, 1'b1, FIXED ? 32'h80000000 : 32'hFFFFFFFF, !FIXED);
        vecs[10] = mk(2'b01, 32'h3, 5'd31, 2'b11, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'h00000006, 1'b0);
        vecs[11] = mk(2'b10, 32'h0, 5'd0, 2'b00, 32'h80000000, 5'd31, 2'b01, 1'b1, 2'b10, 1'b1, 32'h00000001, 1'b1);

        // reset state, with requests present while reset is high
        req_valid = 2'b11;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'h0);
        chk("reset.resp_valid", 32'(resp_valid), 32'h0);
        chk("reset.resp_q", resp_q, 32'h0);
        chk("reset.resp_id", 32'(resp_id), 32'h0);
        req_valid = 2'b00;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), vecs[i]);

        // backpressure: FULL (q=1,id=1), resp_ready low for 3 cycles
        for (int i = 0; i < 3; i++) begin
            h = mk(2'b11, 32'h0000FFFF, 5'd8, 2'b00, 32'h0000FFFF, 5'd8, 2'b01, 1'b0, 2'b00, 1'b1, 32'h00000001, 1'b1);
            step($sformatf("hold%0d", i), h);
        end
        // release: back-to-back, no bubble
        h = mk(2'b11, 32'h0000FFFF, 5'd8, 2'b00, 32'h0000FFFF, 5'd8, 2'b01, 1'b1, 2'b01, 1'b1, 32'h00FFFF00, 1'b0);
        step("release0", h);
        h = mk(2'b11, 32'h0000FFFF, 5'd8, 2'b00, 32'h0000FFFF, 5'd8, 2'b01, 1'b1,
               FIXED ? 2'b01 : 2'b10, 1'b1, FIXED ? 32'h00FFFF00 : 32'h000000FF, !FIXED);
        step("release1", h);
        // leave pointer at 1 and register FULL before the reset
        h = mk(2'b01, 32'h0000FFFF, 5'd8, 2'b00, 32'h0000FFFF, 5'd8, 2'b01, 1'b1, 2'b01, 1'b1, 32'h00FFFF00, 1'b0);
        step("prereset", h);

        // asynchronous reset mid-cycle while FULL
        req_valid = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        chk("areset.resp_valid", 32'(resp_valid), 32'h0);
        chk("areset.resp_q", resp_q, 32'h0);
        chk("areset.resp_id", 32'(resp_id), 32'h0);
        chk("areset.req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postreset.req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("postreset.resp_valid", 32'(resp_valid), 32'h1);
        chk("postreset.resp_id", 32'(resp_id), 32'h0);
        chk("postreset.resp_q", resp_q, 32'h00FFFF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single execute-stage `barrel_shift` datapath between up to four requesters (e.g. ALU shift path, address-generation, CSR/bit-manip unit). It grants one request per cycle using round-robin arbitration and launches it through the shifter. It holds the result in a one-entry output register with a valid/ready handshake. The response carries the requester index so the consumer can route it.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2–4.
- `IDW`, default 1: width of the requester index, equal to `$clog2(NREQ)`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, NREQ: per-requester request valid.
- `req_a`, input, NREQ×32: operand per requester.
- `req_shift`, input, NREQ×5: shift amount per requester.
- `req_op`, input, NREQ×2: shift op per requester.
  - 00 logical left.
  - 01 logical right.
  - 10 arithmetic right.
  - 11 rotate right.
- `req_ready`, output, NREQ: one-hot grant; the request is accepted this cycle.
- `resp_valid`, output, 1: result register holds data.
- `resp_q`, output, 32: shifted result.
- `resp_id`, output, IDW: index of the requester that produced `resp_q`.
- `resp_ready`, input, 1: consumer accepts the result this cycle.

## Operation
- Output register has two states:
  - EMPTY to FULL on a grant.
  - FULL to EMPTY on `resp_ready` with no grant.
  - FULL stays FULL on `resp_ready` with a grant (back-to-back transfer).
  - FULL stays FULL on no `resp_ready` (hold).
- `can_accept` = EMPTY | `resp_ready`.
  - A grant is issued only when `can_accept` is high and at least one `req_valid` is high.
  - At most one `req_ready` bit is high, and only for a valid requester.
  - `req_ready` is combinational from `req_valid`, the round-robin pointer, the state and `resp_ready`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Round-robin arbitration:
  - Pointer `rr_ptr` (IDW bits) names the highest-priority index.
  - The search runs `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
  - On a grant to index g, `rr_ptr` ← (g+1) mod NREQ.
  - With no grant, the pointer holds.
- Shifter:
  - The granted operand/shift/op are muxed into one `barrel_shift` instance.
  - With no grant, the mux selects index 0 (don't-care).
  - On a grant, `resp_q` ← shifter `q` and `resp_id` ← g.
- Shifter arithmetic:
  - Shift amount is 5 bits; shift 0 passes `a` unchanged for every op.
  - Arithmetic right replicates `a[31]`.
  - Rotate right wraps `a[shift-1:0]` into the top bits.
- While FULL and `resp_ready` is low, `resp_q`/`resp_id` are stable and every `req_ready` is 0.
- Requester handshake: a requester whose `req_valid` is high must hold its operands until it sees its `req_ready` bit.
- Reset mid-operation: the result register is discarded (state EMPTY) and no response is emitted for the discarded request.

## Timing
- Latency: request accepted in cycle N → `resp_valid` high in cycle N+1.
- Throughput: one result per cycle while `resp_ready` stays high.
- Reset values:
  - `resp_valid` = 0, `resp_q` = 0, `resp_id` = 0, `rr_ptr` = 0.
  - `req_ready` = 0 while `reset` is high.
- Simultaneous `resp_ready` and grant in the same cycle: the old result leaves and the new one loads; `resp_valid` stays 1.
- Single active requester: it is granted every cycle the output can accept, regardless of `rr_ptr`.

## Configuration
- `SHIFT_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, lowest index wins.
  - `rr_ptr` is not implemented and is treated as constant 0.
- `SHIFT_ARB_FIXED_PRIO_EN` undefined: round-robin as above (default build).

## Structure
- Shared package `shift_pkg` holds:
  - `shift_op_e` enum: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - `shift_req_t` struct: a, shift, op.
  - `XLEN`=32.
- Ports `req_a`/`req_shift`/`req_op` pack as `shift_req_t` arrays inside the block.
- Sub-module `rr_arbiter` (parameter NREQ): takes `req_valid`, `rr_ptr`, `enable`; outputs one-hot grant and encoded index.
- The existing `barrel_shift` is instantiated directly; no changes to it.

## Test plan
- Single request: req0 a=F000DEAD, op=01, shift=4, `resp_ready`=1.
  - Next cycle `resp_valid`=1, `resp_q`=0F000DEA, `resp_id`=0.
- Op sweep on requester 1 with a=F000DEAD, shift=4:
  - op 00 → 000DEAD0.
  - op 10 → FF000DEA.
  - op 11 → DF000DEA.
  - op 01, shift=0 → F000DEAD.
- Both requesters valid continuously, `resp_ready`=1.
  - Grants alternate 0,1,0,1.
  - `resp_id` follows one cycle later.
  - Fixed-prio build: always 0.
- Backpressure: `resp_ready`=0 for 3 cycles with result FULL.
  - `req_ready`=0 throughout and `resp_q` is stable.
  - On release, back-to-back transfer occurs with no bubble.
- Reset asserted asynchronously mid-cycle while FULL: `resp_valid` drops immediately and `rr_ptr`=0.
  - After reset release, the first grant goes to req0 when both requesters are valid.
